// File: rtl/ioctl_pkg.sv
// Shared ioctl upload definitions: address width, upload index, responder states.
package ioctl_pkg;

    localparam int unsigned IOCTL_ADDR_W    = 25;
    localparam logic [7:0]  IOCTL_IDX_NVRAM = 8'h03;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } upl_state_t;

    // True when addr lies in [base, base+len); one guard bit avoids wrap near the top of the space.
    function automatic logic in_window(input logic [IOCTL_ADDR_W-1:0] addr,
                                       input logic [IOCTL_ADDR_W-1:0] base,
                                       input logic [IOCTL_ADDR_W:0]   len);
        logic [IOCTL_ADDR_W:0] a;
        logic [IOCTL_ADDR_W:0] b;
        a = {1'b0, addr};
        b = {1'b0, base};
        return (a >= b) && ((a - b) < len);
    endfunction

endpackage

// File: rtl/hiscore_upload_if.sv
// Read port of the CPU-shared work RAM as seen by the upload responder.
interface hiscore_upload_if #(
    parameter int unsigned ADDR_W = 10
) ();

    logic              ram_req;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_ack;
    logic [7:0]        ram_q;

    modport master (output ram_req, output ram_addr, input ram_ack, input ram_q);
    modport slave  (input ram_req, input ram_addr, output ram_ack, output ram_q);

endinterface

// File: rtl/hiscore_upload.sv
// Serves data_io upload reads from the shared work RAM, pausing the core and
// tracking byte count, checksum and dropped strobes for each session.
module hiscore_upload
    import ioctl_pkg::*;
#(
    parameter int unsigned              ADDR_W = 10,
    parameter logic [IOCTL_ADDR_W-1:0]  BASE   = 25'h0,
    parameter int unsigned              LEN    = 1024
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    ioctl_upload,
    input  logic                    ioctl_rd,
    input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
    output logic [7:0]              ioctl_din,
    output logic                    ioctl_din_valid,
    hiscore_upload_if.master        ram,
    output logic                    pause,
    output logic [ADDR_W:0]         byte_cnt,
    output logic [7:0]              checksum,
    output logic                    overrun,
    output logic                    done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned WIN_W = IOCTL_ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [WIN_W-1:0] WIN_LEN = WIN_W'(LEN);

    upl_state_t              state_q, state_d;
    logic                    upload_q, upload_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [IOCTL_ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic                    ram_req_q, ram_req_d;
    logic [ADDR_W-1:0]       ram_addr_q, ram_addr_d;
    logic [7:0]              din_q, din_d;
    logic                    din_valid_q, din_valid_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              sum_q, sum_d;
    logic                    overrun_q, overrun_d;
    logic                    done_q, done_d;
    logic                    pause_q, pause_d;

    logic                    rd_c;
    logic                    upload_rise_c;
    logic                    upload_fall_c;
    logic                    cmpl;
    logic                    svc;
    logic [IOCTL_ADDR_W-1:0] svc_addr;

    assign rd_c          = ioctl_rd & ioctl_upload;
    assign upload_rise_c = ioctl_upload & ~upload_q;
    assign upload_fall_c = ~ioctl_upload & upload_q;

    // Next state; a completion and the service of the next read may share one cycle.
    always_comb begin
        state_d      = state_q;
        upload_d     = ioctl_upload;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        ram_req_d    = ram_req_q;
        ram_addr_d   = ram_addr_q;
        din_d        = din_q;
        din_valid_d  = din_valid_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        overrun_d    = overrun_q;
        done_d       = 1'b0;
        pause_d      = ioctl_upload | (state_q != IDLE);
        cmpl         = 1'b0;
        svc          = 1'b0;
        svc_addr     = ioctl_addr;

        if (upload_rise_c) begin
            cnt_d       = '0;
            sum_d       = '0;
            overrun_d   = 1'b0;
            din_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                done_d = upload_fall_c;
                svc    = rd_c;
            end
            REQ: begin
                if (!ioctl_upload) begin
                    pend_valid_d = 1'b0;
                    if (ram.ram_ack) begin
                        cmpl    = 1'b1;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (ram.ram_ack) begin
                    cmpl         = 1'b1;
                    state_d      = IDLE;
                    pend_valid_d = 1'b0;
                    // A strobe landing with the ack and an empty slot goes straight out as the next read.
                    if (pend_valid_q) begin
                        svc       = 1'b1;
                        svc_addr  = pend_addr_q;
                        overrun_d = overrun_d | rd_c;
                    end else begin
                        svc = rd_c;
                    end
                end else if (rd_c) begin
                    if (pend_valid_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = ioctl_addr;
                    end
                end
            end
            DRAIN: begin
                if (ram.ram_ack) begin
                    cmpl    = 1'b1;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cmpl) begin
            din_d       = ram.ram_q;
            din_valid_d = 1'b1;
            ram_req_d   = 1'b0;
            sum_d       = sum_d + ram.ram_q;
            if (cnt_d != CNT_MAX) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
        end

        if (svc) begin
            din_valid_d = 1'b0;
            if (in_window(svc_addr, BASE, WIN_LEN)) begin
                ram_addr_d = ADDR_W'(svc_addr - BASE);
                ram_req_d  = 1'b1;
                state_d    = REQ;
            end else begin
                din_d       = 8'hFF;
                din_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            upload_q     <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            ram_req_q    <= 1'b0;
            ram_addr_q   <= '0;
            din_q        <= 8'hFF;
            din_valid_q  <= 1'b0;
            cnt_q        <= '0;
            sum_q        <= '0;
            overrun_q    <= 1'b0;
            done_q       <= 1'b0;
            pause_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            upload_q     <= upload_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            ram_req_q    <= ram_req_d;
            ram_addr_q   <= ram_addr_d;
            din_q        <= din_d;
            din_valid_q  <= din_valid_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            overrun_q    <= overrun_d;
            done_q       <= done_d;
            pause_q      <= pause_d;
        end
    end

    assign ram.ram_req     = ram_req_q;
    assign ram.ram_addr    = ram_addr_q;
    assign ioctl_din       = din_q;
    assign ioctl_din_valid = din_valid_q;
    assign pause           = pause_q;
    assign byte_cnt        = cnt_q;
    assign checksum        = sum_q;
    assign overrun         = overrun_q;
    assign done            = done_q;

endmodule
